// File: rtl/ps2_move_pkg.sv
// Shared types and constants for the PS/2 movement decoder: prefix FSM states,
// scancode values, direction indices and scancode-to-direction mask helpers.
package ps2_move_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } state_e;

    localparam logic [7:0] SC_E0    = 8'hE0;
    localparam logic [7:0] SC_F0    = 8'hF0;

    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;

    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;

    localparam logic [7:0] SC_BAT_OK   = 8'hAA;
    localparam logic [7:0] SC_BAT_FAIL = 8'hFC;
    localparam logic [7:0] SC_OVR0     = 8'h00;
    localparam logic [7:0] SC_OVR1     = 8'hFF;
    localparam logic [7:0] SC_ACK      = 8'hFA;
    localparam logic [7:0] SC_ECHO     = 8'hEE;
    localparam logic [7:0] SC_RESEND   = 8'hFE;

    localparam int DIR_UP    = 0;
    localparam int DIR_DOWN  = 1;
    localparam int DIR_LEFT  = 2;
    localparam int DIR_RIGHT = 3;

    // One-hot direction mask for an extended arrow final byte; zero if not an arrow.
    function automatic logic [3:0] arrow_mask(input logic [7:0] code);
        logic [3:0] m;
        m = '0;
        case (code)
            SC_UP:    m[DIR_UP]    = 1'b1;
            SC_DOWN:  m[DIR_DOWN]  = 1'b1;
            SC_LEFT:  m[DIR_LEFT]  = 1'b1;
            SC_RIGHT: m[DIR_RIGHT] = 1'b1;
            default:  m = '0;
        endcase
        return m;
    endfunction

    function automatic logic [3:0] wasd_mask(input logic [7:0] code);
        logic [3:0] m;
        m = '0;
        case (code)
            SC_W:    m[DIR_UP]    = 1'b1;
            SC_S:    m[DIR_DOWN]  = 1'b1;
            SC_A:    m[DIR_LEFT]  = 1'b1;
            SC_D:    m[DIR_RIGHT] = 1'b1;
            default: m = '0;
        endcase
        return m;
    endfunction

    // Keyboard self-test results and buffer overruns invalidate every held key.
    function automatic logic is_flush_code(input logic [7:0] code);
        return (code == SC_BAT_OK) || (code == SC_BAT_FAIL) ||
               (code == SC_OVR0)   || (code == SC_OVR1);
    endfunction

endpackage

// File: rtl/ps2_move_decoder.sv
// PS/2 scancode stream to held Up/Down/Left/Right levels with a prefix timeout.
// Optional MOVE_WASD_EN adds W/S/A/D as separately held sources OR'd per direction.
//
// Handshake: ps2_key_pressed is a one-cycle valid strobe with no ready; each
// strobe carries exactly one byte on ps2_key_data, which is ignored otherwise.
module ps2_move_decoder
    import ps2_move_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 2_500_000
) (
    input  logic       iCLK,
    input  logic       iRST,
    input  logic [7:0] ps2_key_data,
    input  logic       ps2_key_pressed,
    output logic       move_up,
    output logic       move_down,
    output logic       move_left,
    output logic       move_right,
    output logic       key_evt,
    output state_e     dbg_state
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    arrow_q, arrow_d;
    logic [3:0]    dir_q, dir_d;
    logic          key_evt_q, key_evt_d;
    logic [3:0]    amask;

`ifdef MOVE_WASD_EN
    logic [3:0]    wasd_q, wasd_d;
    logic [3:0]    wmask;
    assign wmask = wasd_mask(ps2_key_data);
`endif

    assign amask = arrow_mask(ps2_key_data);

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            arrow_q   <= '0;
            key_evt_q <= 1'b0;
`ifdef MOVE_WASD_EN
            wasd_q    <= '0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            arrow_q   <= arrow_d;
            key_evt_q <= key_evt_d;
`ifdef MOVE_WASD_EN
            wasd_q    <= wasd_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        arrow_d = arrow_q;
`ifdef MOVE_WASD_EN
        wasd_d  = wasd_q;
`endif
        if (ps2_key_pressed) begin
            // A strobe always beats a simultaneous timeout expiry.
            cnt_d = '0;
            case (ps2_key_data)
                SC_E0: state_d = ST_EXT;
                SC_F0: state_d = (state_q == ST_EXT || state_q == ST_EXT_BRK) ?
                                 ST_EXT_BRK : ST_BRK;
                SC_ACK, SC_ECHO, SC_RESEND: state_d = ST_IDLE;
                default: begin
                    state_d = ST_IDLE;
                    if (is_flush_code(ps2_key_data)) begin
                        arrow_d = '0;
`ifdef MOVE_WASD_EN
                        wasd_d  = '0;
`endif
                    end else begin
                        if (state_q == ST_EXT)
                            arrow_d = arrow_q | amask;
                        else if (state_q == ST_EXT_BRK)
                            arrow_d = arrow_q & ~amask;
`ifdef MOVE_WASD_EN
                        if (state_q == ST_IDLE)
                            wasd_d = wasd_q | wmask;
                        else if (state_q == ST_BRK)
                            wasd_d = wasd_q & ~wmask;
`endif
                    end
                end
            endcase
        end else if (state_q != ST_IDLE) begin
            // Stale prefix: drop it but keep the held bits; counter saturates.
            if (cnt_q == CNT_LAST)
                state_d = ST_IDLE;
            else
                cnt_d = cnt_q + 1'b1;
        end
    end

`ifdef MOVE_WASD_EN
    assign dir_q = arrow_q | wasd_q;
    assign dir_d = arrow_d | wasd_d;
`else
    assign dir_q = arrow_q;
    assign dir_d = arrow_d;
`endif

    assign key_evt_d = (dir_d != dir_q);

    assign move_up    = dir_q[DIR_UP];
    assign move_down  = dir_q[DIR_DOWN];
    assign move_left  = dir_q[DIR_LEFT];
    assign move_right = dir_q[DIR_RIGHT];
    assign key_evt    = key_evt_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_ps2_move_decoder.sv
// Directed bench for ps2_move_decoder with a short prefix timeout (16 cycles).
// Observed vector layout: {key_evt, move_right, move_left, move_down, move_up}.
module tb_ps2_move_decoder;
    import ps2_move_pkg::*;

    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data;
    logic       pressed;
    logic       move_up, move_down, move_left, move_right, key_evt;
    state_e     dbg_state;

    int checks = 0;
    int errors = 0;
    logic [4:0] exp_q[$];

    ps2_move_decoder #(.TIMEOUT_CYCLES(TO)) dut (
        .iCLK            (clk),
        .iRST            (rst),
        .ps2_key_data    (data),
        .ps2_key_pressed (pressed),
        .move_up         (move_up),
        .move_down       (move_down),
        .move_left       (move_left),
        .move_right      (move_right),
        .key_evt         (key_evt),
        .dbg_state       (dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [4:0] obs();
        return {key_evt, move_right, move_left, move_down, move_up};
    endfunction

    task automatic check_out(input string tag, input logic [4:0] exp);
        checks++;
        assert (obs() === exp) else begin
            errors++;
            $error("FAIL %s got %b exp %b", tag, obs(), exp);
        end
    endtask

    task automatic check_state(input string tag, input state_e exp);
        checks++;
        assert (dbg_state === exp) else begin
            errors++;
            $error("FAIL %s got state %0d exp %0d", tag, dbg_state, exp);
        end
    endtask

    // Called at a negedge: strobe one byte, then compare the registered result.
    task automatic send(input logic [7:0] b, input logic [4:0] exp, input string tag);
        exp_q.push_back(exp);
        data    = b;
        pressed = 1'b1;
        @(negedge clk);
        pressed = 1'b0;
        data    = 8'($urandom_range(0, 255));
        check_out(tag, exp_q.pop_front());
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        rst     = 1'b1;
        pressed = 1'b0;
        data    = 8'h00;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check_out("reset_out", 5'b0_0000);
        check_state("reset_state", ST_IDLE);

        // Up make then break
        send(SC_E0, 5'b0_0000, "up_e0");
        check_state("ext_state", ST_EXT);
        send(SC_UP, 5'b1_0001, "up_make");
        idle(1);
        check_out("evt_one_cycle", 5'b0_0001);
        send(SC_E0, 5'b0_0001, "up_brk_e0");
        send(SC_F0, 5'b0_0001, "up_brk_f0");
        check_state("ext_brk_state", ST_EXT_BRK);
        send(SC_UP, 5'b1_0000, "up_break");

        // Keypad 8 and typematic Left
        send(SC_UP, 5'b0_0000, "keypad8");
        send(SC_E0, 5'b0_0000, "left_e0_1");
        send(SC_LEFT, 5'b1_0100, "left_make");
        send(SC_E0, 5'b0_0100, "left_e0_2");
        send(SC_LEFT, 5'b0_0100, "left_rep1");
        send(SC_E0, 5'b0_0100, "left_e0_3");
        send(SC_LEFT, 5'b0_0100, "left_rep2");
        send(SC_E0, 5'b0_0100, "left_brk_e0");
        send(SC_F0, 5'b0_0100, "left_brk_f0");
        send(SC_LEFT, 5'b1_0000, "left_break");

        // Flush codes and benign codes
        send(SC_E0, 5'b0_0000, "ur_e0a");
        send(SC_UP, 5'b1_0001, "ur_up");
        send(SC_E0, 5'b0_0001, "ur_e0b");
        send(SC_RIGHT, 5'b1_1001, "ur_right");
        send(SC_BAT_OK, 5'b1_0000, "bat_ok_flush");
        send(SC_E0, 5'b0_0000, "dn_e0a");
        send(SC_DOWN, 5'b1_0010, "dn_make_a");
        send(SC_BAT_FAIL, 5'b1_0000, "bat_fail_flush");
        send(SC_E0, 5'b0_0000, "dn_e0b");
        send(SC_DOWN, 5'b1_0010, "dn_make_b");
        send(SC_ACK, 5'b0_0010, "ack_keep");
        send(SC_E0, 5'b0_0010, "e0_before_echo");
        send(SC_ECHO, 5'b0_0010, "echo_keep");
        check_state("echo_idle", ST_IDLE);
        send(SC_OVR1, 5'b1_0000, "ovr_ff_flush");
        send(SC_E0, 5'b0_0000, "e1_e0");
        send(8'hE1, 5'b0_0000, "e1_unmapped");
        check_state("e1_idle", ST_IDLE);
        send(SC_UP, 5'b0_0000, "after_e1_keypad");

        // Prefix timeout
        send(SC_E0, 5'b0_0000, "to20_e0");
        idle(20);
        check_state("to20_idle", ST_IDLE);
        send(SC_DOWN, 5'b0_0000, "to20_keypad2");
        send(SC_E0, 5'b0_0000, "to10_e0");
        idle(10);
        check_state("to10_ext", ST_EXT);
        send(SC_DOWN, 5'b1_0010, "to10_down");
        send(SC_E0, 5'b0_0010, "dn_brk_e0");
        send(SC_F0, 5'b0_0010, "dn_brk_f0");
        send(SC_DOWN, 5'b1_0000, "dn_break");
        send(SC_E0, 5'b0_0000, "to_edge_e0");
        idle(TO - 1);
        check_state("to_edge_still_ext", ST_EXT);
        idle(1);
        check_state("to_edge_expired", ST_IDLE);
        send(SC_E0, 5'b0_0000, "to_race_e0");
        idle(TO - 1);
        send(SC_DOWN, 5'b1_0010, "to_race_strobe_wins");
        send(SC_OVR0, 5'b1_0000, "ovr_00_flush");

        // Reset mid-sequence while Right is held
        send(SC_E0, 5'b0_0000, "rr_e0");
        send(SC_RIGHT, 5'b1_1000, "rr_make");
        send(SC_E0, 5'b0_1000, "rr_brk_e0");
        send(SC_F0, 5'b0_1000, "rr_brk_f0");
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_out("mid_reset_out", 5'b0_0000);
        check_state("mid_reset_state", ST_IDLE);
        send(SC_RIGHT, 5'b0_0000, "post_reset_74");
        send(SC_E0, 5'b0_0000, "post_reset_e0");
        send(SC_RIGHT, 5'b1_1000, "post_reset_right");

        // Data without strobe is ignored
        data = SC_E0;
        @(negedge clk);
        check_state("nostrobe_idle", ST_IDLE);
        send(SC_UP, 5'b0_1000, "nostrobe_keypad");
        send(SC_E0, 5'b0_1000, "r_brk_e0");
        send(SC_F0, 5'b0_1000, "r_brk_f0");
        send(SC_RIGHT, 5'b1_0000, "r_break");

`ifdef MOVE_WASD_EN
        send(SC_W, 5'b1_0001, "w_make");
        send(SC_E0, 5'b0_0001, "wu_e0");
        send(SC_UP, 5'b0_0001, "wu_arrow_make");
        send(SC_F0, 5'b0_0001, "w_brk_f0");
        check_state("w_brk_state", ST_BRK);
        send(SC_W, 5'b0_0001, "w_break_held");
        send(SC_E0, 5'b0_0001, "wu_brk_e0");
        send(SC_F0, 5'b0_0001, "wu_brk_f0");
        send(SC_UP, 5'b1_0000, "wu_arrow_break");
        send(SC_D, 5'b1_1000, "d_make");
        send(SC_BAT_OK, 5'b1_0000, "wasd_flush");
`else
        send(SC_W, 5'b0_0000, "w_unmapped");
        send(SC_F0, 5'b0_0000, "w_brk_f0");
        send(SC_W, 5'b0_0000, "w_brk_unmapped");
        check_state("w_idle", ST_IDLE);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
